// File: rtl/uart_bus_pkg.sv
// Shared definitions for the memory-mapped UART responder: register offsets,
// CON bit positions, FSM state types and the baud divider helper.
package uart_bus_pkg;

  localparam logic [31:0] OFS_TXD = 32'h0;
  localparam logic [31:0] OFS_RXD = 32'h4;
  localparam logic [31:0] OFS_CON = 32'h8;

  localparam int CON_TX_IRQ_EN = 0;
  localparam int CON_RX_IRQ_EN = 1;
  localparam int CON_TX_DONE   = 2;
  localparam int CON_RX_READY  = 3;
  localparam int CON_TX_BUSY   = 4;
  localparam int CON_FRAME_ERR = 5;
  localparam int CON_OVERRUN   = 6;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Cycles per bit; below 4 the half-bit start re-sample degenerates.
  function automatic int calc_div(input int clk_hz, input int baud);
    int d;
    d = clk_hz / baud;
    return (d < 4) ? 4 : d;
  endfunction

endpackage

// File: rtl/uart_bus_responder_rx_core.sv
// Receive path: 2-FF synchroniser, start/data/stop FSM and bit counter.
// Emits the received byte with a one-cycle valid pulse, or a frame-error pulse.
//
// state    | meaning
// RX_IDLE  | waiting for a synchronised high->low edge
// RX_START | waiting DIV/2 cycles to re-check the start bit
// RX_DATA  | sampling 8 data bits, LSB first, one per DIV cycles
// RX_STOP  | sampling the stop bit once
module uart_rx_core
  import uart_bus_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       ferr_o
);

  localparam int CNT_W = $clog2(DIV);

  rx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       sh_q;
  logic [7:0]       byte_q;
  logic             valid_q;
  logic             ferr_q;
  logic             s1_q, s2_q, s3_q;
  logic             tick;

  assign tick    = (cnt_q == '0);
  assign byte_o  = byte_q;
  assign valid_o = valid_q;
  assign ferr_o  = ferr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      s3_q    <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      s1_q    <= rx_i;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (s3_q && !s2_q) begin
            state_q <= RX_START;
            cnt_q   <= CNT_W'(DIV / 2 - 1);
          end
        end
        RX_START: begin
          if (tick) begin
            if (s2_q) begin
              state_q <= RX_IDLE;
            end else begin
              state_q <= RX_DATA;
              cnt_q   <= CNT_W'(DIV - 1);
              bit_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (tick) begin
            sh_q  <= {s2_q, sh_q[7:1]};
            cnt_q <= CNT_W'(DIV - 1);
            if (bit_q == 3'd7) begin
              state_q <= RX_STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (tick) begin
            state_q <= RX_IDLE;
            if (s2_q) begin
              byte_q  <= sh_q;
              valid_q <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_bus_responder.sv
// Memory-mapped UART at TXD/RXD/CON on the CPU bus, with TX serialiser and flags.
// Define UART_RX_FIFO_EN for a 4-entry RX FIFO instead of a single holding register.
//
// state    | meaning
// TX_IDLE  | line high, waiting for a TXD store
// TX_START | driving the start bit for DIV cycles
// TX_DATA  | driving 8 data bits, LSB first, DIV cycles each
// TX_STOP  | driving the stop bit for DIV cycles
module uart_bus_responder
  import uart_bus_pkg::*;
#(
  parameter int          CLK_HZ    = 100_000_000,
  parameter int          BAUD      = 9600,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        pc31,
  input  logic        UART_RX,
  output logic        UART_TX,
  output logic        irqout
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD);
  localparam int CNT_W = $clog2(DIV);

  logic sel_txd, sel_rxd, sel_con;
  logic wr_txd, wr_con, rd_rxd, rd_con;

  assign sel_txd = (addr == BASE_ADDR + OFS_TXD);
  assign sel_rxd = (addr == BASE_ADDR + OFS_RXD);
  assign sel_con = (addr == BASE_ADDR + OFS_CON);
  assign wr_txd  = wr & sel_txd;
  assign wr_con  = wr & sel_con;
  assign rd_rxd  = rd & sel_rxd;
  assign rd_con  = rd & sel_con;

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];

  // ---------------- transmitter ----------------
  tx_state_e        tx_state_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [2:0]       tx_bit_q;
  logic [7:0]       tx_sh_q;
  logic             tx_q;
  logic             tx_tick, tx_busy, tx_done_set;

  assign tx_tick     = (tx_cnt_q == '0);
  assign tx_busy     = (tx_state_q != TX_IDLE);
  assign tx_done_set = (tx_state_q == TX_STOP) && tx_tick;
  assign UART_TX     = tx_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (wr_txd) begin
            tx_state_q <= TX_START;
            tx_cnt_q   <= CNT_W'(DIV - 1);
            tx_sh_q    <= wdata[7:0];
            tx_q       <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_tick) begin
            tx_state_q <= TX_DATA;
            tx_cnt_q   <= CNT_W'(DIV - 1);
            tx_bit_q   <= '0;
            tx_q       <= tx_sh_q[0];
            tx_sh_q    <= {1'b0, tx_sh_q[7:1]};
          end else begin
            tx_cnt_q <= tx_cnt_q - CNT_W'(1);
          end
        end
        TX_DATA: begin
          if (tx_tick) begin
            tx_cnt_q <= CNT_W'(DIV - 1);
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= TX_STOP;
              tx_q       <= 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q + 3'd1;
              tx_q     <= tx_sh_q[0];
              tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - CNT_W'(1);
          end
        end
        TX_STOP: begin
          if (tx_tick) begin
            tx_state_q <= TX_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q - CNT_W'(1);
          end
        end
        default: begin
          tx_state_q <= TX_IDLE;
          tx_q       <= 1'b1;
        end
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic [7:0] rx_byte;
  logic       rx_valid, rx_ferr;

  uart_rx_core #(.DIV(DIV)) u_rx_core (
    .clk     (clk),
    .reset   (reset),
    .rx_i    (UART_RX),
    .byte_o  (rx_byte),
    .valid_o (rx_valid),
    .ferr_o  (rx_ferr)
  );

  logic       rx_ready;
  logic [7:0] rx_head;
  logic       ovr_set;

`ifdef UART_RX_FIFO_EN
  logic [7:0] fifo_q [4];
  logic [1:0] wp_q, rp_q;
  logic [2:0] fcnt_q;
  logic       push, pop;

  assign pop      = rd_rxd && (fcnt_q != 3'd0);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push     = rx_valid && ((fcnt_q != 3'd4) || pop);
  assign ovr_set  = rx_valid && !push;
  assign rx_ready = (fcnt_q != 3'd0);
  assign rx_head  = fifo_q[rp_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      fcnt_q <= '0;
    end else begin
      if (push) begin
        fifo_q[wp_q] <= rx_byte;
        wp_q         <= wp_q + 2'd1;
      end
      if (pop) rp_q <= rp_q + 2'd1;
      case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + 3'd1;
        2'b01:   fcnt_q <= fcnt_q - 3'd1;
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end
`else
  logic [7:0] hold_q;
  logic       rdy_q;

  // A byte landing in the cycle its predecessor is read is not an overrun.
  assign ovr_set  = rx_valid && rdy_q && !rd_rxd;
  assign rx_ready = rdy_q;
  assign rx_head  = hold_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
      rdy_q  <= 1'b0;
    end else if (rx_valid) begin
      hold_q <= rx_byte;
      rdy_q  <= 1'b1;
    end else if (rd_rxd) begin
      rdy_q <= 1'b0;
    end
  end
`endif

  // ---------------- control / status ----------------
  logic [1:0] en_q;
  logic       tx_done_q, frame_err_q, overrun_q;

  // Set events take priority over the clear-on-read of CON.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q        <= '0;
      tx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (wr_con) en_q <= wdata[1:0];
      if (tx_done_set)  tx_done_q <= 1'b1;
      else if (rd_con)  tx_done_q <= 1'b0;
      if (rx_ferr)      frame_err_q <= 1'b1;
      else if (rd_con)  frame_err_q <= 1'b0;
      if (ovr_set)      overrun_q <= 1'b1;
      else if (rd_con)  overrun_q <= 1'b0;
    end
  end

  logic [31:0] con_word;

  always_comb begin
    con_word                = '0;
    con_word[CON_TX_IRQ_EN] = en_q[0];
    con_word[CON_RX_IRQ_EN] = en_q[1];
    con_word[CON_TX_DONE]   = tx_done_q;
    con_word[CON_RX_READY]  = rx_ready;
    con_word[CON_TX_BUSY]   = tx_busy;
    con_word[CON_FRAME_ERR] = frame_err_q;
    con_word[CON_OVERRUN]   = overrun_q;
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (sel_rxd)      rdata = {24'b0, rx_head};
      else if (sel_con) rdata = con_word;
    end
  end

  assign irqout = ~pc31 & ((en_q[0] & tx_done_q) | (en_q[1] & rx_ready));

endmodule

// File: tb/tb_uart_bus_responder.sv
// Directed self-checking bench for uart_bus_responder at DIV=16.
module tb_uart_bus_responder;

  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;

  logic        clk, reset, rd, wr, pc31, UART_RX, UART_TX, irqout;
  logic [31:0] addr, wdata, rdata;
  int          n_vec, n_err;

  uart_bus_responder #(.CLK_HZ(160), .BAUD(10), .BASE_ADDR(32'h4000_0018)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .pc31(pc31), .UART_RX(UART_RX), .UART_TX(UART_TX), .irqout(irqout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); addr = a; wdata = d; wr = 1'b1;
    @(negedge clk); wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk); addr = a; rd = 1'b1; #1 d = rdata;
    @(negedge clk); rd = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); UART_RX = fr[k];
      repeat (15) @(negedge clk);
    end
    @(negedge clk); UART_RX = 1'b1;
    repeat (15) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b0; rd = 1'b0; wr = 1'b0; pc31 = 1'b0; UART_RX = 1'b1;
    addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    n_vec++; if (UART_TX !== 1'b1) begin n_err++; $display("FAIL rst_tx: got %b want 1", UART_TX); end
    n_vec++; if (irqout !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b want 0", irqout); end
    reset = 1'b1;
    bus_read(A_CON, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL rst_con: got %h want 0", d); end
    bus_read(A_TXD, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL rst_txd_read: got %h want 0", d); end
  endtask

  task automatic test_tx_frame;
    logic [9:0]  fr;
    logic [31:0] d;
    fr = {1'b1, 8'h5A, 1'b0};
    @(negedge clk); addr = A_TXD; wdata = 32'h5A; wr = 1'b1;
    for (int n = 0; n <= 170; n++) begin
      @(negedge clk);
      if (n == 0)  wr = 1'b0;
      if (n == 79) begin addr = A_TXD; wdata = 32'h33; wr = 1'b1; end
      if (n == 80) wr = 1'b0;
      if (n < 160 && (n % 16) == 8) begin
        n_vec++;
        if (UART_TX !== fr[n / 16]) begin
          n_err++; $display("FAIL tx_bit%0d: got %b want %b", n / 16, UART_TX, fr[n / 16]);
        end
      end
      if (n == 100) begin
        addr = A_CON; rd = 1'b1; #1;
        n_vec++; if (rdata[4:2] !== 3'b100) begin n_err++; $display("FAIL tx_busy_mid: got %b want 100", rdata[4:2]); end
      end
      if (n == 101) rd = 1'b0;
      if (n == 160) begin
        addr = A_CON; rd = 1'b1; #1;
        n_vec++; if (rdata[4:2] !== 3'b001) begin n_err++; $display("FAIL tx_done_160: got %b want 001", rdata[4:2]); end
      end
      if (n == 161) rd = 1'b0;
      if (n == 170) begin
        n_vec++; if (UART_TX !== 1'b1) begin n_err++; $display("FAIL tx_idle: got %b want 1", UART_TX); end
      end
    end
    bus_read(A_CON, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL tx_done_clr: got %h want 0", d); end
  endtask

  task automatic test_reset_midframe;
    bus_write(A_CON, 32'h3);
    bus_write(A_TXD, 32'h00);
    repeat (40) @(negedge clk);
    n_vec++; if (UART_TX !== 1'b0) begin n_err++; $display("FAIL mid_pre: got %b want 0", UART_TX); end
    addr = A_CON; rd = 1'b1;
    reset = 1'b0; #1;
    n_vec++; if (UART_TX !== 1'b1) begin n_err++; $display("FAIL mid_rst_tx: got %b want 1", UART_TX); end
    n_vec++; if (irqout !== 1'b0) begin n_err++; $display("FAIL mid_rst_irq: got %b want 0", irqout); end
    n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL mid_rst_con: got %h want 0", rdata); end
    rd = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    n_vec++; if (UART_TX !== 1'b1) begin n_err++; $display("FAIL mid_after: got %b want 1", UART_TX); end
  endtask

  task automatic test_rx_receive;
    logic [9:0]  fr;
    logic [31:0] d;
    fr = {1'b1, 8'hA5, 1'b0};
    bus_write(A_CON, 32'h2);
    @(negedge clk); UART_RX = 1'b0;
    for (int n = 1; n <= 160; n++) begin
      @(negedge clk);
      if (n < 160) UART_RX = fr[n / 16];
      else         UART_RX = 1'b1;
      if (n == 150) begin
        n_vec++; if (irqout !== 1'b0) begin n_err++; $display("FAIL rx_irq_early: got %b want 0", irqout); end
      end
      if (n == 160) begin
        n_vec++; if (irqout !== 1'b1) begin n_err++; $display("FAIL rx_irq_160: got %b want 1", irqout); end
      end
    end
    pc31 = 1'b1; #1;
    n_vec++; if (irqout !== 1'b0) begin n_err++; $display("FAIL rx_irq_kmask: got %b want 0", irqout); end
    pc31 = 1'b0;
    bus_read(A_RXD, d);
    n_vec++; if (d !== 32'h0000_00A5) begin n_err++; $display("FAIL rx_data: got %h want 000000a5", d); end
    n_vec++; if (irqout !== 1'b0) begin n_err++; $display("FAIL rx_irq_clr: got %b want 0", irqout); end
  endtask

  task automatic test_rx_errors;
    logic [31:0] d;
    @(negedge clk); UART_RX = 1'b0;
    repeat (5) @(negedge clk);
    UART_RX = 1'b1;
    repeat (200) @(negedge clk);
    bus_read(A_CON, d);
    n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL glitch_con: got %h want 2", d); end
    send_frame(8'h55, 1'b0);
    bus_read(A_CON, d);
    n_vec++; if (d !== 32'h22) begin n_err++; $display("FAIL ferr_con: got %h want 22", d); end
    bus_read(A_CON, d);
    n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL ferr_clr: got %h want 2", d); end
  endtask

  task automatic test_overrun;
    logic [31:0] d;
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    send_frame(8'h03, 1'b1);
`ifdef UART_RX_FIFO_EN
    bus_read(A_CON, d);
    n_vec++; if (d !== 32'h0A) begin n_err++; $display("FAIL fifo_con: got %h want 0a", d); end
    for (int i = 1; i <= 3; i++) begin
      bus_read(A_RXD, d);
      n_vec++; if (d !== 32'(i)) begin n_err++; $display("FAIL fifo_pop%0d: got %h want %h", i, d, 32'(i)); end
    end
    bus_read(A_CON, d);
    n_vec++; if (d !== 32'h02) begin n_err++; $display("FAIL fifo_empty: got %h want 02", d); end
`else
    bus_read(A_RXD, d);
    n_vec++; if (d !== 32'h03) begin n_err++; $display("FAIL ovr_data: got %h want 03", d); end
    bus_read(A_CON, d);
    n_vec++; if (d !== 32'h42) begin n_err++; $display("FAIL ovr_con: got %h want 42", d); end
    bus_read(A_CON, d);
    n_vec++; if (d !== 32'h02) begin n_err++; $display("FAIL ovr_clr: got %h want 02", d); end
`endif
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    bus_write(A_TXD, 32'hFF);
    repeat (159) @(negedge clk);
    addr = A_TXD; wdata = 32'h00; wr = 1'b1;
    @(negedge clk);
    n_vec++; if (UART_TX !== 1'b1) begin n_err++; $display("FAIL b2b_gap: got %b want 1", UART_TX); end
    @(negedge clk); wr = 1'b0;
    n_vec++; if (UART_TX !== 1'b0) begin n_err++; $display("FAIL b2b_start: got %b want 0", UART_TX); end
    repeat (170) @(negedge clk);
    bus_read(A_CON, d);
    n_vec++; if (d !== 32'h06) begin n_err++; $display("FAIL b2b_con: got %h want 06", d); end
  endtask

  task automatic test_kernel_mask;
    logic [31:0] d;
    bus_write(A_CON, 32'h3);
    pc31 = 1'b1;
    bus_write(A_TXD, 32'h81);
    repeat (170) @(negedge clk);
    n_vec++; if (irqout !== 1'b0) begin n_err++; $display("FAIL kmask_hi: got %b want 0", irqout); end
    pc31 = 1'b0; #1;
    n_vec++; if (irqout !== 1'b1) begin n_err++; $display("FAIL kmask_lo: got %b want 1", irqout); end
    addr = A_CON; rd = 1'b0; #1;
    n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rdata_unsel: got %h want 0", rdata); end
    bus_read(A_CON, d);
    n_vec++; if (d !== 32'h07) begin n_err++; $display("FAIL kmask_con: got %h want 07", d); end
    n_vec++; if (irqout !== 1'b0) begin n_err++; $display("FAIL kmask_clr: got %b want 0", irqout); end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    test_reset;
    test_tx_frame;
    test_reset_midframe;
    test_rx_receive;
    test_rx_errors;
    test_overrun;
    test_back_to_back;
    test_kernel_mask;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
